// File: rtl/prng_arbiter.sv
// prng_arbiter
// Shares one xoroshiro128+ generator among N requesters. Each cycle at most
// one requester is granted (round-robin starting after the previous winner)
// and receives the current generator output; the generator only advances when
// a word is actually issued, so no two grants ever carry the same word.
// A seed can be loaded at run time, optionally followed by WARMUP discarded
// generator steps during which no grants are issued.
//
// Ports:
//   clk        in   rising-edge clock
//   resn       in   asynchronous active-low reset
//   req        in   [N]   per-requester request level
//   gnt        out  [N]   one-hot grant pulse, owner of rnd_data this cycle
//   rnd_valid  out        rnd_data/rnd_id valid (equals |gnt)
//   rnd_data   out  [64]  random word (holds when not valid)
//   rnd_id     out  [$clog2(N)] granted requester index (holds when not valid)
//   seed_we    in         single-cycle seed load strobe (highest priority)
//   seed_s0    in   [64]  seed for s0
//   seed_s1    in   [64]  seed for s1
//   busy       out        warm-up in progress
module prng_arbiter #(
  parameter int N      = 4,
  parameter int WARMUP = 16
) (
  input  logic                 clk,
  input  logic                 resn,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 rnd_valid,
  output logic [63:0]          rnd_data,
  output logic [$clog2(N)-1:0] rnd_id,
  input  logic                 seed_we,
  input  logic [63:0]          seed_s0,
  input  logic [63:0]          seed_s1,
  output logic                 busy
);

  localparam int IDW = $clog2(N);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WARM = 1'b1;

  localparam logic [7:0]     WARM_INIT = 8'(WARMUP);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(N - 1);

  logic [63:0]    s0_q, s0_d;
  logic [63:0]    s1_q, s1_d;
  logic [0:0]     state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [IDW-1:0] last_q, last_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           rnd_valid_q, rnd_valid_d;
  logic [63:0]    rnd_data_q, rnd_data_d;
  logic [IDW-1:0] rnd_id_q, rnd_id_d;

  // One generator step from the current state.
  logic [63:0] sx;
  logic [63:0] s0_step;
  logic [63:0] s1_step;

  assign sx      = s0_q ^ s1_q;
  assign s0_step = {s0_q[8:0], s0_q[63:9]} ^ sx ^ (sx << 14);  // rotl 55
  assign s1_step = {sx[27:0], sx[63:28]};                      // rotl 36

  // Round-robin pick: first set request at last+1, last+2, ... (mod N).
  // cand is one bit wider than an index so last+k never overflows before
  // the modulo correction.
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [IDW:0]   cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) begin
        cand = cand - (IDW+1)'(N);
      end
      if (!pick_found && req[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    s0_d        = s0_q;
    s1_d        = s1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    rnd_data_d  = rnd_data_q;
    rnd_id_d    = rnd_id_q;

    if (seed_we) begin
      // The all-zero state is a fixed point of the generator; substitute
      // the reset state instead.
      if ((seed_s0 == 64'd0) && (seed_s1 == 64'd0)) begin
        s0_d = 64'd1;
        s1_d = 64'd0;
      end else begin
        s0_d = seed_s0;
        s1_d = seed_s1;
      end
      if (WARMUP > 0) begin
        state_d = ST_WARM;
        cnt_d   = WARM_INIT;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_WARM) begin
      s0_d  = s0_step;
      s1_d  = s1_step;
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) begin
        state_d = ST_RUN;
      end
    end else if (pick_found) begin
      gnt_d[pick_idx] = 1'b1;
      rnd_valid_d     = 1'b1;
      rnd_id_d        = pick_idx;
      rnd_data_d      = s0_q + s1_q;  // output uses the pre-step state
      s0_d            = s0_step;
      s1_d            = s1_step;
      last_d          = pick_idx;
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      s0_q        <= 64'd1;
      s1_q        <= 64'd0;
      state_q     <= ST_RUN;
      cnt_q       <= 8'd0;
      last_q      <= LAST_INIT;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= 64'd0;
      rnd_id_q    <= '0;
    end else begin
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
      rnd_id_q    <= rnd_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign rnd_id    = rnd_id_q;
  assign busy      = (state_q == ST_WARM);

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Shares one xoroshiro128+ generator among `N` requesters. Grants are round-robin, one 64-bit random word per cycle, and the generator advances only when a word is issued. It also handles run-time reseeding, with an optional warm-up of discarded steps. It sits between the PRNG datapath and the consumer blocks, so no requester ever receives a word that another requester also received.

## Interface
- `N`, 4: number of requesters, 2..16.
- `WARMUP`, 16: generator steps discarded after a seed load, 0..255.
- `clk`  in  1  single clock, rising edge.
- `resn`  in  1  asynchronous active-low reset.
- `req`  in  N  per-requester request level, sampled each cycle.
- `gnt`  out  N  one-hot, one-cycle grant pulse; marks the requester owning `rnd_data` this cycle.
- `rnd_valid`  out  1  `rnd_data`/`rnd_id` valid this cycle; equals `|gnt`.
- `rnd_data`  out  64  random word.
- `rnd_id`  out  $clog2(N)  index of the granted requester.
- `seed_we`  in  1  load-seed strobe, single cycle.
- `seed_s0`, `seed_s1`  in  64 each  seed state.
- `busy`  out  1  high while warm-up is in progress.

## Operation
- State: `s0`, `s1` (64b each); FSM {RUN, WARM}; warm-up counter (8b); round-robin pointer `last` ($clog2(N) bits).
- Generator step, identical to the team PRNG:
  - `sx = s0^s1`
  - `s0' = rotl(s0,55) ^ sx ^ (sx<<14)`
  - `s1' = rotl(sx,36)`
  - output word = `s0+s1`, mod 2^64, computed from the pre-step state.
- Reset values:
  - `s0`=1, `s1`=0, FSM=RUN, `last`=N-1.
  - `gnt`=0, `rnd_valid`=0, `rnd_data`=0, `rnd_id`=0, `busy`=0.
- RUN, `seed_we`=0, `req`≠0:
  - Pick the first set `req` bit searching from `last+1` upward, wrapping modulo N.
  - Register `gnt` one-hot, `rnd_id`, `rnd_data = s0+s1`, `rnd_valid`=1.
  - Step the generator once; set `last` = granted index.
- RUN, `req`=0: no step; outputs `gnt`=0, `rnd_valid`=0. `rnd_data`/`rnd_id` hold their last values.
- `seed_we`=1 (any state, highest priority):
  - Load `s0`←`seed_s0`, `s1`←`seed_s1`. If both are zero, load `s0`=1, `s1`=0 instead; the all-zero state is illegal.
  - No grant this cycle, even if `req`≠0.
  - If `WARMUP`>0: counter←`WARMUP`, FSM→WARM, `busy`=1 from the next cycle. If `WARMUP`=0: stay in RUN.
  - `last` is unchanged.
- WARM:
  - Step the generator every cycle and decrement the counter; no grants; `busy`=1.
  - When the counter reaches 1 and steps: FSM→RUN, `busy`=0 on the next cycle. Exactly `WARMUP` steps are discarded.
- `seed_we` during WARM restarts the load and the counter; the last seed wins.
- Asynchronous reset mid-operation restores all reset values immediately, regardless of FSM state.

## Timing
- Latency: `req` sampled at edge t → `gnt`/`rnd_valid`/`rnd_data` registered, visible after edge t+1.
- Throughput: one word per cycle, sustained.
- A requester holding `req` high with other requesters active is granted at most once every k cycles, where k = number of active requesters.
- Handshake: no back-pressure. A requester keeps `req` high until it has counted its grants; a `gnt` pulse is a completed transfer.
- Word issued at a grant = `s0+s1` before that grant's step. Consecutive grants (any requesters) receive consecutive generator outputs.
- After `seed_we` at edge t with `WARMUP`=W>0:
  - `busy` is high for cycles t+1..t+W.
  - The earliest grant is registered at edge t+W+1 and carries output index W of the new seed.
- With `WARMUP`=0: the earliest grant is at t+1 carrying output 0 of the seed.
- Simultaneous `seed_we` and `req`: seed wins; the request is served on a later cycle if still held.

## Test plan
- Reset, `req`=4'b0001 held:
  - `rnd_data` sequence 0x0000000000000001, then 0x0080001000004001.
  - `gnt`=0001 and `rnd_id`=0 each cycle.
- `req`=4'b1111 held 8 cycles from reset → `rnd_id` sequence 0,1,2,3,0,1,2,3. Data matches the reference model's outputs 0..7 in order.
- `req`=4'b1010 → grants alternate 1,3,1,3; the generator steps once per grant. With `req`=0 in between, the next word continues the sequence without gaps.
- `seed_we` with `seed_s0`=`seed_s1`=0, `WARMUP`=16:
  - State becomes s0=1, s1=0; `busy` high for exactly 16 cycles.
  - First granted word = output 16 of the reset sequence.
- `seed_we` coinciding with `req`=0001 → no `gnt` that cycle. A second `seed_we` at warm-up count 5 restarts the counter; `busy` stays high 16 cycles from the second strobe.
- `resn` pulsed low during WARM with `req` active:
  - `gnt`/`rnd_valid`/`busy` drop immediately.
  - After release, the first word is 0x0000000000000001 to requester 0.
